// File: rtl/wave_pattern_loader.sv
// rtl/wave_pattern_loader.sv - emits 256 strobed samples of a generated or streamed waveform
module wave_pattern_loader #(
    parameter int PULSE_GAP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] wave_sel,
    input  logic [7:0] duty,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    output logic       wave_wr_pulse,
    output logic [7:0] wave_data,
    output logic       busy,
    output logic       done,
    output logic       sel_err,
    output logic [8:0] point_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_STROBE = 3'd2,
        S_GAP    = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    localparam logic [2:0] SEL_SINE   = 3'd0;
    localparam logic [2:0] SEL_SQUARE = 3'd1;
    localparam logic [2:0] SEL_TRI    = 3'd2;
    localparam logic [2:0] SEL_SAW    = 3'd3;
    localparam logic [2:0] SEL_CUSTOM = 3'd4;
    localparam logic [3:0] GAP_LAST   = 4'(PULSE_GAP - 1);

    state_t      state, state_nxt;
    logic [2:0]  sel_q;
    logic [7:0]  duty_q;
    logic [7:0]  idx;
    logic [3:0]  gap_cnt;
    logic [7:0]  data_q;
    logic [8:0]  count_q;
    logic        sel_err_q;
    logic        sel_legal;
    logic        gap_end;
    logic        is_custom;
    logic [6:0]  sine_k;
    logic [6:0]  sine_mag;
    logic [7:0]  gen_sample;

    // Quarter-wave table: round(127*sin(2*pi*k/256)) for k = 0..64
    function automatic logic [6:0] sine_rom(input logic [6:0] k);
        logic [6:0] v;
        case (k)
            7'd0:  v = 7'd0;   7'd1:  v = 7'd3;   7'd2:  v = 7'd6;   7'd3:  v = 7'd9;
            7'd4:  v = 7'd12;  7'd5:  v = 7'd16;  7'd6:  v = 7'd19;  7'd7:  v = 7'd22;
            7'd8:  v = 7'd25;  7'd9:  v = 7'd28;  7'd10: v = 7'd31;  7'd11: v = 7'd34;
            7'd12: v = 7'd37;  7'd13: v = 7'd40;  7'd14: v = 7'd43;  7'd15: v = 7'd46;
            7'd16: v = 7'd49;  7'd17: v = 7'd51;  7'd18: v = 7'd54;  7'd19: v = 7'd57;
            7'd20: v = 7'd60;  7'd21: v = 7'd63;  7'd22: v = 7'd65;  7'd23: v = 7'd68;
            7'd24: v = 7'd71;  7'd25: v = 7'd73;  7'd26: v = 7'd76;  7'd27: v = 7'd78;
            7'd28: v = 7'd81;  7'd29: v = 7'd83;  7'd30: v = 7'd85;  7'd31: v = 7'd88;
            7'd32: v = 7'd90;  7'd33: v = 7'd92;  7'd34: v = 7'd94;  7'd35: v = 7'd96;
            7'd36: v = 7'd98;  7'd37: v = 7'd100; 7'd38: v = 7'd102; 7'd39: v = 7'd104;
            7'd40: v = 7'd106; 7'd41: v = 7'd107; 7'd42: v = 7'd109; 7'd43: v = 7'd111;
            7'd44: v = 7'd112; 7'd45: v = 7'd113; 7'd46: v = 7'd115; 7'd47: v = 7'd116;
            7'd48: v = 7'd117; 7'd49: v = 7'd118; 7'd50: v = 7'd120; 7'd51: v = 7'd121;
            7'd52: v = 7'd122; 7'd53: v = 7'd122; 7'd54: v = 7'd123; 7'd55: v = 7'd124;
            7'd56: v = 7'd125; 7'd57: v = 7'd125; 7'd58: v = 7'd126; 7'd59: v = 7'd126;
            7'd60: v = 7'd126; 7'd61: v = 7'd127; 7'd62: v = 7'd127; 7'd63: v = 7'd127;
            default: v = 7'd127;
        endcase
        return v;
    endfunction

    assign sel_legal = (wave_sel <= SEL_CUSTOM);
    assign gap_end   = (gap_cnt == GAP_LAST);
    assign is_custom = (sel_q == SEL_CUSTOM);

    // Mirror the second quadrant onto the first: 128 - q is -q modulo 128
    assign sine_k   = (idx[6:0] <= 7'd64) ? idx[6:0] : (7'd0 - idx[6:0]);
    assign sine_mag = sine_rom(sine_k);

    always_comb begin
        gen_sample = 8'h00;
        case (sel_q)
            SEL_SINE:   gen_sample = idx[7] ? (8'd128 - {1'b0, sine_mag})
                                            : (8'd128 + {1'b0, sine_mag});
            SEL_SQUARE: gen_sample = (idx < duty_q) ? 8'hFF : 8'h00;
            SEL_TRI:    gen_sample = idx[7] ? ~{idx[6:0], 1'b0} : {idx[6:0], 1'b0};
            SEL_SAW:    gen_sample = idx;
            default:    gen_sample = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start && sel_legal) state_nxt = S_FETCH;
            S_FETCH:  if (!is_custom || s_valid) state_nxt = S_STROBE;
            S_STROBE: state_nxt = S_GAP;
            S_GAP:    if (gap_end) state_nxt = (idx == 8'hFF) ? S_FINISH : S_FETCH;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        s_ready       = 1'b0;
        wave_wr_pulse = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            S_FETCH:  begin busy = 1'b1; s_ready = is_custom; end
            S_STROBE: begin busy = 1'b1; wave_wr_pulse = 1'b1; end
            S_GAP:    busy = 1'b1;
            S_FINISH: begin busy = 1'b1; done = 1'b1; end
            default:  busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q     <= 3'd0;
            duty_q    <= 8'd0;
            idx       <= 8'd0;
            gap_cnt   <= 4'd0;
            data_q    <= 8'd0;
            count_q   <= 9'd0;
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= (state == S_IDLE) && start && !sel_legal;
            case (state)
                S_IDLE: begin
                    if (start && sel_legal) begin
                        sel_q   <= wave_sel;
                        duty_q  <= duty;
                        idx     <= 8'd0;
                        count_q <= 9'd0;
                    end
                end
                S_FETCH: begin
                    gap_cnt <= 4'd0;
                    if (!is_custom) begin
                        data_q <= gen_sample;
                    end else if (s_valid) begin
                        data_q <= s_data;
                    end
                end
                S_STROBE: count_q <= count_q + 9'd1;
                S_GAP: begin
                    gap_cnt <= gap_cnt + 4'd1;
                    if (gap_end && idx != 8'hFF) begin
                        idx <= idx + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign wave_data   = data_q;
    assign point_count = count_q;
    assign sel_err     = sel_err_q;

endmodule

// File: doc/wave_pattern_loader.md
# wave_pattern_loader

Upstream feeder for the DAC waveform engine. On command it produces exactly 256 eight-bit samples of a selected waveform: sine, square, triangle, sawtooth, or a custom table taken from a byte stream. Each sample is delivered as a single-cycle `wave_wr_pulse` with stable `wave_data`, followed by a guaranteed low gap, so an edge-detecting consumer with a free-running 256-entry write pointer is always loaded completely and in order. `busy` and `done` report load progress to the control/CSR layer.

## Interface
- `PULSE_GAP`, default 1: number of low cycles after each write pulse; legal range 1..15.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: level-sampled load request; accepted only in IDLE.
- `wave_sel` input 3: waveform select. 0 = sine, 1 = square, 2 = triangle, 3 = sawtooth, 4 = custom; 5–7 are illegal.
- `duty` input 8: square high-count, latched at start.
- `s_valid` input 1: custom byte valid.
- `s_data` input 8: custom byte.
- `s_ready` output 1: custom byte ready.
- `wave_wr_pulse` output 1: one-cycle write strobe to the DAC engine.
- `wave_data` output 8: sample value; stable while the strobe is high.
- `busy` output 1: high while a load is in progress.
- `done` output 1: one-cycle pulse when a load completes.
- `sel_err` output 1: one-cycle pulse when `start` is seen with an illegal `wave_sel`.
- `point_count` output 9: number of samples emitted in the current or last load (0..256).

## Operation
- **FSM states:** IDLE, FETCH, STROBE, GAP, FINISH.
- **IDLE:**
  - If `start` is high with legal `wave_sel`: latch `wave_sel` and `duty`, clear the index and `point_count`, go to FETCH.
  - If `start` is high with illegal `wave_sel`: pulse `sel_err` and stay in IDLE.
- **FETCH:**
  - Generated modes compute sample[idx] into the output register, then go to STROBE.
  - Custom mode holds `s_ready` high and stays in FETCH until `s_valid && s_ready`. It then registers `s_data` and goes to STROBE. No timeout.
- **STROBE:** `wave_wr_pulse` = 1 for exactly one cycle, then go to GAP. `point_count` increments on exit.
- **GAP:** `wave_wr_pulse` = 0 for `PULSE_GAP` cycles. Then:
  - go to FINISH if idx = 255;
  - otherwise increment idx and return to FETCH.
- **FINISH:** `done` = 1 for one cycle, then go to IDLE.
- **Sample rules** (idx is 8 bits; all arithmetic unsigned, 8-bit results):
  - Sine uses a 65-entry quarter ROM, Q[k] = round(127·sin(2πk/256)), k = 0..64, values 0..127.
    - q = idx mod 128; Q index is q for q ≤ 64, otherwise 128 − q.
    - sample = 128 + Q for idx < 128, and 128 − Q otherwise.
  - Square: sample = 255 if idx < duty, else 0. `duty` = 0 gives all 0.
  - Triangle: sample = 2·idx for idx < 128, else 511 − 2·idx.
  - Sawtooth: sample = idx.
- **Boundaries:**
  - `start` while busy is ignored; latched `wave_sel`/`duty` are unaffected by input changes mid-load.
  - `s_valid` outside custom FETCH is ignored and `s_ready` stays 0.
  - Exactly 256 strobes occur per accepted start, never more and never fewer.
  - Asynchronous reset mid-load aborts immediately. Downstream reset is shared, so its pointer realigns.
- **Reset values:** all outputs 0, state IDLE, idx 0.

## Timing
- `start` sampled at edge T leads to FETCH after T.
- In generated modes, sample 0 strobe is high in cycle T+2. After that, strobe period = 2 + `PULSE_GAP` cycles.
- In custom mode, a byte accepted at edge A produces a strobe in the cycle after A. `s_ready` is low during STROBE and GAP.
- `wave_data` changes only on entry to STROBE and holds until the next STROBE entry.
- Total generated load is 256·(2 + `PULSE_GAP`) cycles from the first FETCH, with `done` high one cycle after the final GAP.
- `busy` is high from T+1 through the FINISH cycle inclusive.
- `point_count` reads 256 after the last strobe and holds until the next accepted start.

## Test plan
- **Sawtooth, `PULSE_GAP` = 1:** `start` with sel = 3. Require:
  - 256 strobes with data 0..255 in order, each strobe period 3 cycles;
  - first strobe at T+2;
  - one `done`; final `point_count` = 256.
- **Sine:** `start` with sel = 0. Require:
  - samples 0, 64, 128, 192 = 128, 255, 128, 1;
  - sample 32 = 128 + round(127·sin(π/4)) = 218.
- **Square and triangle:**
  - Square with `duty` = 100: require samples 0..99 = 255 and 100..255 = 0.
  - Triangle: require idx 127 → 254, 128 → 255, 255 → 1.
- **Custom stream with bursty `s_valid`:** send 256 bytes 0xFF − i with random gaps. Require:
  - strobes match the sent bytes in order;
  - `s_ready` low during STROBE and GAP;
  - no extra strobes while the stream is idle.
- **Illegal select and start while busy:** sel = 6 with start. Require a `sel_err` pulse, no strobes, `busy` 0. Then, during a sine load, toggle `start` and `wave_sel`: require no effect on the load.
- **Reset mid-load:** assert `rst_n` low at sample 100. Require all outputs 0 and IDLE. Then require a restart to produce a full 256-sample load with a correct `done`.
